// File: rtl/bird_ctrl.sv
// Purpose : flappy-bird sprite controller: flap sync/edge detect, gravity/flap physics, READY/FLY/DEAD FSM.
// Latency : flap needs 2 sync clocks before its edge is seen; y/vel/state move only on frame ticks, boxes follow combinationally.
// Backpressure: none; a flap edge or hit is held pending until the next frame tick consumes it.
module bird_ctrl #(
  parameter int IX       = 160,
  parameter int IY       = 240,
  parameter int H_SIZE   = 8,
  parameter int D_HEIGHT = 480,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 6,
  parameter int MAX_FALL = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        i_flap,
  input  logic        i_hit,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2,
  output logic [1:0]  o_state,
  output logic [15:0] o_time
);

  typedef enum logic [1:0] {READY = 2'd0, FLY = 2'd1, DEAD = 2'd2} state_t;

  localparam logic [11:0]        Y_START  = 12'(IY);
  localparam logic [11:0]        Y_LAUNCH = 12'(IY - FLAP_VEL);
  localparam logic [11:0]        Y_CEIL   = 12'(H_SIZE);
  localparam logic [11:0]        Y_FLOOR  = 12'(D_HEIGHT - H_SIZE);
  localparam logic signed [12:0] Y_CEIL_S  = 13'(H_SIZE);
  localparam logic signed [12:0] Y_FLOOR_S = 13'(D_HEIGHT - H_SIZE);
  localparam logic signed [7:0]  V_FLAP   = 8'(-FLAP_VEL);
  localparam logic signed [8:0]  V_MAX    = 9'(MAX_FALL);
  localparam logic signed [8:0]  V_GRAV   = 9'(GRAVITY);

  state_t             state_q;
  logic [11:0]        y_q, y_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [15:0]        time_q;
  logic               sync1_q, sync2_q, sync3_q;
  logic               flap_pend_q, hit_pend_q, landed_q;

  logic               tick, flap_edge, flap_now, hit_now, at_floor, at_ceil;
  logic signed [8:0]  vel_sum;
  logic signed [7:0]  vel_grav, step_vel;
  logic signed [12:0] y_sum;
  logic [15:0]        time_inc;

  assign tick      = i_ani_stb & i_animate;
  assign flap_edge = sync2_q & ~sync3_q;
  // A flap edge arriving in the tick cycle itself counts for that tick.
  assign flap_now  = flap_pend_q | flap_edge;
  assign hit_now   = hit_pend_q | (i_hit & (state_q == FLY));
  assign time_inc  = (time_q == 16'hFFFF) ? time_q : time_q + 16'd1;

  // One physics step: gravity (or flap while flying unhurt), then ceiling/floor clamping.
  always_comb begin
    vel_sum  = {vel_q[7], vel_q} + V_GRAV;
    vel_grav = (vel_sum > V_MAX) ? V_MAX[7:0] : vel_sum[7:0];
    step_vel = ((state_q == FLY) && !hit_now && flap_now) ? V_FLAP : vel_grav;
    y_sum    = $signed({1'b0, y_q}) + $signed({{5{step_vel[7]}}, step_vel});
    at_floor = (y_sum >= Y_FLOOR_S);
    at_ceil  = (y_sum < Y_CEIL_S);
    y_d      = y_sum[11:0];
    vel_d    = step_vel;
    if (at_floor) begin
      y_d   = Y_FLOOR;
      vel_d = 8'sd0;
    end else if (at_ceil) begin
      y_d   = Y_CEIL;
      vel_d = 8'sd0;
    end
  end

  // Flap synchronizer, pending flags and the READY/FLY/DEAD state machine.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      flap_pend_q <= 1'b0;
      hit_pend_q  <= 1'b0;
      landed_q    <= 1'b0;
      state_q     <= READY;
      y_q         <= Y_START;
      vel_q       <= 8'sd0;
      time_q      <= 16'd0;
    end else begin
      sync1_q     <= i_flap;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      flap_pend_q <= tick ? 1'b0 : flap_now;
      if ((state_q == FLY) && i_hit) hit_pend_q <= 1'b1;
      if (tick) begin
        case (state_q)
          READY: begin
            if (flap_now) begin
              state_q <= FLY;
              y_q     <= Y_LAUNCH;
              vel_q   <= V_FLAP;
              time_q  <= 16'd0;
            end
          end
          FLY: begin
            time_q   <= time_inc;
            y_q      <= y_d;
            vel_q    <= vel_d;
            landed_q <= at_floor;
            if (hit_now || at_floor) state_q <= DEAD;
          end
          DEAD: begin
            if (landed_q) begin
              if (flap_now) begin
                state_q    <= READY;
                y_q        <= Y_START;
                vel_q      <= 8'sd0;
                hit_pend_q <= 1'b0;
                landed_q   <= 1'b0;
              end
            end else begin
              y_q      <= y_d;
              vel_q    <= vel_d;
              landed_q <= at_floor;
            end
          end
          default: state_q <= READY;
        endcase
      end
    end
  end

  assign o_x1    = 12'(IX - H_SIZE);
  assign o_x2    = 12'(IX + H_SIZE);
  assign o_y1    = y_q - Y_CEIL;
  assign o_y2    = y_q + Y_CEIL;
  assign o_state = state_q;
  assign o_time  = time_q;

endmodule
